// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults, pointer type and helper for the DP-RAM FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_DEF_D_W = 8;
    localparam int FIFO_DEF_A_W = 8;

    typedef logic [FIFO_DEF_A_W-1:0] fifo_ptr_t;

    function automatic int fifo_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_dp_ram_core.sv
// ============================================================================
// Module   : fifo_dp_ram_core
// Brief    : Simple dual-port RAM, synchronous write, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_dp_ram_core
    import fifo_pkg::*;
#(
    parameter int D_W = FIFO_DEF_D_W,
    parameter int A_W = FIFO_DEF_A_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           we,
    input  logic [A_W-1:0] waddr,
    input  logic [D_W-1:0] wdata,
    input  logic           re,
    input  logic [A_W-1:0] raddr,
    output logic [D_W-1:0] rdata
);

    logic [D_W-1:0] r_mem [0:(2**A_W)-1];

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_sync_dp_ram.sv
// ============================================================================
// Module   : fifo_sync_dp_ram
// Brief    : Single-clock FIFO on a dual-port RAM with level/error flags.
//            Define FIFO_SHOWAHEAD_EN for first-word-fall-through output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_dp_ram
    import fifo_pkg::*;
#(
    parameter int D_W      = FIFO_DEF_D_W,
    parameter int A_W      = FIFO_DEF_A_W,
    parameter int AF_LEVEL = (2**A_W) - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [D_W-1:0] data,
    input  logic           rd_en,
    output logic [D_W-1:0] q,
    output logic           full,
    output logic           empty,
    output logic           almost_full,
    output logic           almost_empty,
    output logic [A_W:0]   usedw,
    output logic           overflow,
    output logic           underflow
);

    localparam int           c_DEPTH   = 2**A_W;
    localparam logic [A_W:0] c_DEPTH_W = (A_W+1)'(c_DEPTH);
    localparam logic [A_W:0] c_AF      = (A_W+1)'(AF_LEVEL);
    localparam logic [A_W:0] c_AE      = (A_W+1)'(AE_LEVEL);

    logic [A_W-1:0] r_wptr;
    logic [A_W-1:0] r_rptr;
    logic [A_W:0]   r_usedw;
    logic [A_W:0]   w_usedw_nxt;
    logic           r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic           w_wr_acc, w_rd_acc, w_ram_re, w_empty_nxt;

    always_comb begin
        w_wr_acc    = wr_en & ~r_full;
        w_rd_acc    = rd_en & ~r_empty;
        w_usedw_nxt = r_usedw;
        if (w_wr_acc & ~w_rd_acc) begin
            w_usedw_nxt = r_usedw + (A_W+1)'(1);
        end else if (~w_wr_acc & w_rd_acc) begin
            w_usedw_nxt = r_usedw - (A_W+1)'(1);
        end
    end

`ifdef FIFO_SHOWAHEAD_EN
    // The RAM read register doubles as the prefetch stage; r_q_valid marks
    // it holding the head word, which is already counted in usedw.
    logic r_q_valid;
    logic w_q_valid_nxt;
    logic w_ram_has;

    always_comb begin
        w_ram_has     = r_usedw > {{A_W{1'b0}}, r_q_valid};
        w_ram_re      = w_ram_has & (~r_q_valid | w_rd_acc);
        w_q_valid_nxt = w_ram_re | (r_q_valid & ~w_rd_acc);
        w_empty_nxt   = ~w_q_valid_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= w_q_valid_nxt;
        end
    end
`else
    always_comb begin
        w_ram_re    = w_rd_acc;
        w_empty_nxt = (w_usedw_nxt == '0);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usedw <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + A_W'(1);
            end
            if (w_ram_re) begin
                r_rptr <= r_rptr + A_W'(1);
            end
            r_usedw <= w_usedw_nxt;
            r_full  <= (w_usedw_nxt == c_DEPTH_W);
            r_empty <= w_empty_nxt;
            r_af    <= (w_usedw_nxt >= c_AF);
            r_ae    <= (w_usedw_nxt <= c_AE);
            r_ovf   <= wr_en & r_full;
            r_udf   <= rd_en & r_empty;
        end
    end

    fifo_dp_ram_core #(
        .D_W (D_W),
        .A_W (A_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (w_wr_acc),
        .waddr (r_wptr),
        .wdata (data),
        .re    (w_ram_re),
        .raddr (r_rptr),
        .rdata (q)
    );

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign usedw        = r_usedw;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

`default_nettype wire
